// File: rtl/delay_timer_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : delay_arb_pkg
//  Description : Shared constants for the delay timer arbiter. Holds the FSM
//                state encodings, default parameter values and the prescaler
//                counter width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package delay_arb_pkg;

    // Default instance parameters
    localparam int c_DEF_DELAY_W  = 16;
    localparam int c_DEF_PRESCALE = 50000;

    // FSM state encodings (kept as plain 2-bit constants for legacy users)
    typedef logic [1:0] state_t;
    localparam state_t c_IDLE  = 2'b00;
    localparam state_t c_LOAD  = 2'b01;
    localparam state_t c_COUNT = 2'b10;
    localparam state_t c_DONE  = 2'b11;

    // Prescaler counter width: ceil(log2(prescale)), never narrower than 1 bit
    function automatic int prescale_w(input int prescale);
        int w;
        w = $clog2(prescale);
        return (w < 1) ? 1 : w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/delay_timer_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : delay_timer_arbiter_if
//  Description : Request/grant bundle between two requesting FSMs and the
//                shared delay timer. master = requester side, slave = timer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface delay_timer_arbiter_if
    import delay_arb_pkg::*;
#(
    parameter int DELAY_W = c_DEF_DELAY_W
) ();

    logic               req0;
    logic               req1;
    logic [DELAY_W-1:0] delay0;
    logic [DELAY_W-1:0] delay1;
    logic               grant0;
    logic               grant1;
    logic               done0;
    logic               done1;
    logic               busy;
    logic [DELAY_W-1:0] remaining;

    modport master (
        output req0, req1, delay0, delay1,
        input  grant0, grant1, done0, done1, busy, remaining
    );

    modport slave (
        input  req0, req1, delay0, delay1,
        output grant0, grant1, done0, done1, busy, remaining
    );

endinterface
`default_nettype wire

// File: rtl/delay_timer_arbiter_tick_prescaler.sv
`default_nettype none
// ============================================================================
//  Module      : tick_prescaler
//  Description : Divides enabled clk cycles by PRESCALE. The counter runs
//                0..PRESCALE-1 while enabled and tick pulses on the last count,
//                i.e. once every PRESCALE enabled cycles. clear wins over enable.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_prescaler
    import delay_arb_pkg::*;
#(
    parameter int PRESCALE = c_DEF_PRESCALE
) (
    input  wire  clk,
    input  wire  reset,
    input  wire  clear,
    input  wire  enable,
    output logic tick
);

    localparam int                 c_CNT_W = prescale_w(PRESCALE);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(PRESCALE - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_count;

    // Cycle counter: wraps at PRESCALE-1, held at zero while cleared
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= (r_count == c_LAST) ? '0 : r_count + c_ONE;
        end
    end

    // With PRESCALE = 1 the count is stuck at 0 == c_LAST, so every enabled cycle ticks
    assign tick = enable && !clear && (r_count == c_LAST);

endmodule
`default_nettype wire

// File: rtl/delay_timer_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : delay_timer_arbiter
//  Description : Shares one prescaled step-delay timer between two requesters.
//                Round-robin grant on contention, one-cycle done pulse to the
//                owner when its delay expires, abort if the owner drops req.
//                All outputs decode from registered state and owner id only.
//  Revision    : 1.0 - initial release
// ============================================================================
module delay_timer_arbiter
    import delay_arb_pkg::*;
#(
    parameter int DELAY_W  = c_DEF_DELAY_W,
    parameter int PRESCALE = c_DEF_PRESCALE
) (
    input  wire                    clk,
    input  wire                    reset,
    delay_timer_arbiter_if.slave   bus
);

    state_t             r_state;
    logic               r_owner;      // 0 = requester 0 holds the timer, 1 = requester 1
    logic               r_ptr;        // requester favoured when both ask at once
    logic [DELAY_W-1:0] r_remaining;

    logic               w_winner;
    logic               w_owner_req;
    logic               w_counting;
    logic               w_tick;

    // Arbitration: a lone requester wins, contention is settled by the pointer
    always_comb begin
        w_winner = 1'b0;
        if (bus.req0 && bus.req1) begin
            w_winner = r_ptr;
        end else begin
            w_winner = bus.req1;
        end
    end

    assign w_owner_req = r_owner ? bus.req1 : bus.req0;
    assign w_counting  = (r_state == c_COUNT);

    // The prescaler only runs in COUNT and restarts from zero on every new grant
    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .reset  (reset),
        .clear  (!w_counting),
        .enable (w_counting),
        .tick   (w_tick)
    );

    // Grant/count FSM with owner latch, pointer and remaining-tick register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_owner     <= 1'b0;
            r_ptr       <= 1'b0;
            r_remaining <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.req0 || bus.req1) begin
                        r_state     <= c_LOAD;
                        r_owner     <= w_winner;
                        r_remaining <= w_winner ? bus.delay1 : bus.delay0;
                    end
                end
                c_LOAD: begin
                    r_state <= (r_remaining == '0) ? c_DONE : c_COUNT;
                end
                c_COUNT: begin
                    if (!w_owner_req) begin
                        // Owner gave up: release silently, but still hand priority over
                        r_state     <= c_IDLE;
                        r_remaining <= '0;
                        r_ptr       <= ~r_owner;
                    end else if (w_tick) begin
                        // Compare against <= 1 so the register can never wrap below zero
                        if (r_remaining <= DELAY_W'(1)) begin
                            r_state     <= c_DONE;
                            r_remaining <= '0;
                        end else begin
                            r_remaining <= r_remaining - DELAY_W'(1);
                        end
                    end
                end
                c_DONE: begin
                    r_ptr   <= ~r_owner;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = (r_state != c_IDLE);
    assign bus.grant0    = (r_state != c_IDLE) && !r_owner;
    assign bus.grant1    = (r_state != c_IDLE) &&  r_owner;
    assign bus.done0     = (r_state == c_DONE) && !r_owner;
    assign bus.done1     = (r_state == c_DONE) &&  r_owner;
    assign bus.remaining = r_remaining;

endmodule
`default_nettype wire

// File: tb/tb_delay_timer_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_delay_timer_arbiter
//  Description : Scoreboard bench for delay_timer_arbiter. Three instances
//                (PRESCALE 4, 2 and 1). Stimulus pushes expected done pulses
//                and expected output samples into queues; a negedge monitor
//                pops and compares them against the DUT outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_delay_timer_arbiter;
    import delay_arb_pkg::*;

    typedef enum int {S_G0, S_G1, S_D0, S_D1, S_BUSY, S_REM} sig_t;

    typedef struct {
        int   cyc;
        int   dut;
        sig_t sig;
        int   exp;
    } obs_t;

    typedef struct {
        int cyc;
        int dut;
        int who;
    } done_t;

    logic  clk = 1'b0;
    logic  reset;
    int    cyc = 0;
    int    n_tests = 0;
    int    n_fail = 0;
    bit    finishing = 1'b0;
    bit    mon_finished = 1'b0;
    obs_t  obs_q[$];
    done_t done_q[$];

    always #5 clk = ~clk;

    // Cycle index: value seen at a negedge = number of rising edges so far
    always @(posedge clk) cyc <= cyc + 1;

    delay_timer_arbiter_if #(.DELAY_W(16)) bus_a ();
    delay_timer_arbiter_if #(.DELAY_W(16)) bus_b ();
    delay_timer_arbiter_if #(.DELAY_W(8))  bus_c ();

    delay_timer_arbiter #(.DELAY_W(16), .PRESCALE(4)) dut_a (.clk(clk), .reset(reset), .bus(bus_a));
    delay_timer_arbiter #(.DELAY_W(16), .PRESCALE(2)) dut_b (.clk(clk), .reset(reset), .bus(bus_b));
    delay_timer_arbiter #(.DELAY_W(8),  .PRESCALE(1)) dut_c (.clk(clk), .reset(reset), .bus(bus_c));

    function automatic string sig_name(input sig_t s);
        case (s)
            S_G0:    return "grant0";
            S_G1:    return "grant1";
            S_D0:    return "done0";
            S_D1:    return "done1";
            S_BUSY:  return "busy";
            default: return "remaining";
        endcase
    endfunction

    function automatic int read_sig(input int d, input sig_t s);
        logic [5:0] f;   // {grant0, grant1, done0, done1, busy, unused}
        int         rem;
        case (d)
            0: begin
                f   = {bus_a.grant0, bus_a.grant1, bus_a.done0, bus_a.done1, bus_a.busy, 1'b0};
                rem = int'(bus_a.remaining);
            end
            1: begin
                f   = {bus_b.grant0, bus_b.grant1, bus_b.done0, bus_b.done1, bus_b.busy, 1'b0};
                rem = int'(bus_b.remaining);
            end
            default: begin
                f   = {bus_c.grant0, bus_c.grant1, bus_c.done0, bus_c.done1, bus_c.busy, 1'b0};
                rem = int'(bus_c.remaining);
            end
        endcase
        case (s)
            S_G0:    return int'(f[5]);
            S_G1:    return int'(f[4]);
            S_D0:    return int'(f[3]);
            S_D1:    return int'(f[2]);
            S_BUSY:  return int'(f[1]);
            default: return rem;
        endcase
    endfunction

    task automatic expect_sig(input int c, input int d, input sig_t s, input int v);
        obs_t o;
        o.cyc = c; o.dut = d; o.sig = s; o.exp = v;
        obs_q.push_back(o);
    endtask

    task automatic expect_done(input int c, input int d, input int w);
        done_t e;
        e.cyc = c; e.dut = d; e.who = w;
        done_q.push_back(e);
    endtask

    task automatic expect_idle(input int c, input int d);
        expect_sig(c, d, S_G0, 0);
        expect_sig(c, d, S_G1, 0);
        expect_sig(c, d, S_D0, 0);
        expect_sig(c, d, S_D1, 0);
        expect_sig(c, d, S_BUSY, 0);
        expect_sig(c, d, S_REM, 0);
    endtask

    task automatic to_cycle(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: compares scheduled samples and every done pulse against the queues
    always @(negedge clk) begin
        obs_t keep[$];
        int   act;
        keep = {};
        foreach (obs_q[i]) begin
            if (obs_q[i].cyc <= cyc) begin
                n_tests++;
                act = read_sig(obs_q[i].dut, obs_q[i].sig);
                if (obs_q[i].cyc < cyc || act != obs_q[i].exp) begin
                    n_fail++;
                    $display("FAIL %s dut%0d cycle %0d: got %0d, expected %0d",
                             sig_name(obs_q[i].sig), obs_q[i].dut, obs_q[i].cyc, act, obs_q[i].exp);
                end
            end else begin
                keep.push_back(obs_q[i]);
            end
        end
        obs_q = keep;

        while (done_q.size() > 0 && done_q[0].cyc < cyc) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_missing dut%0d req%0d: no pulse seen, expected at cycle %0d",
                     done_q[0].dut, done_q[0].who, done_q[0].cyc);
            void'(done_q.pop_front());
        end

        for (int d = 0; d < 3; d++) begin
            for (int w = 0; w < 2; w++) begin
                if (read_sig(d, (w == 0) ? S_D0 : S_D1) != 0) begin
                    n_tests++;
                    if (done_q.size() > 0 && done_q[0].cyc == cyc &&
                        done_q[0].dut == d && done_q[0].who == w) begin
                        void'(done_q.pop_front());
                    end else begin
                        n_fail++;
                        $display("FAIL done_unexpected dut%0d req%0d: pulse at cycle %0d, expected none",
                                 d, w, cyc);
                    end
                end
            end
        end

        if (finishing && !mon_finished) begin
            n_tests++;
            if (obs_q.size() != 0 || done_q.size() != 0) begin
                n_fail++;
                $display("FAIL queues_drained: %0d samples and %0d done pulses left, expected 0 and 0",
                         obs_q.size(), done_q.size());
            end
            mon_finished = 1'b1;
        end
    end

    // Stimulus
    initial begin
        int c;
        int c2;
        int rem_tbl [1:14];

        reset = 1'b1;
        bus_a.req0 = 0; bus_a.req1 = 0; bus_a.delay0 = '0; bus_a.delay1 = '0;
        bus_b.req0 = 0; bus_b.req1 = 0; bus_b.delay0 = '0; bus_b.delay1 = '0;
        bus_c.req0 = 0; bus_c.req1 = 0; bus_c.delay0 = '0; bus_c.delay1 = '0;
        repeat (3) @(negedge clk);

        // Reset state
        c = cyc;
        expect_idle(c + 1, 0);
        expect_sig(c + 1, 1, S_BUSY, 0);
        expect_sig(c + 1, 1, S_REM, 0);
        expect_sig(c + 1, 2, S_BUSY, 0);
        expect_sig(c + 1, 2, S_REM, 0);
        to_cycle(c + 1);
        reset = 1'b0;

        // dut_a (PRESCALE 4): abort of requester 0 with requester 1 pending
        c = cyc;
        bus_a.req0 = 1; bus_a.delay0 = 16'd10;
        bus_a.req1 = 1; bus_a.delay1 = 16'd1;
        expect_sig(c + 1, 0, S_G0, 1);
        expect_sig(c + 1, 0, S_G1, 0);
        expect_sig(c + 1, 0, S_BUSY, 1);
        expect_sig(c + 1, 0, S_REM, 10);
        expect_sig(c + 4, 0, S_REM, 10);
        expect_sig(c + 4, 0, S_G0, 1);
        expect_idle(c + 5, 0);
        expect_sig(c + 6, 0, S_G1, 1);
        expect_sig(c + 6, 0, S_REM, 1);
        expect_done(c + 11, 0, 1);
        expect_sig(c + 12, 0, S_G1, 0);
        to_cycle(c + 4);
        bus_a.req0 = 0;
        to_cycle(c + 11);
        bus_a.req1 = 0;
        to_cycle(c + 13);

        // dut_a: single request, delay 3 -> done in cycle 14
        rem_tbl = '{3, 3, 3, 3, 3, 2, 2, 2, 2, 1, 1, 1, 1, 0};
        c = cyc;
        bus_a.req0 = 1; bus_a.delay0 = 16'd3;
        for (int k = 1; k <= 14; k++) begin
            expect_sig(c + k, 0, S_REM, rem_tbl[k]);
            expect_sig(c + k, 0, S_G0, 1);
            expect_sig(c + k, 0, S_G1, 0);
        end
        expect_done(c + 14, 0, 0);
        expect_sig(c + 15, 0, S_G0, 0);
        expect_sig(c + 15, 0, S_D0, 0);
        to_cycle(c + 14);
        bus_a.req0 = 0;
        to_cycle(c + 16);

        // dut_a: reset while counting with remaining = 5, then contention after reset
        c = cyc;
        bus_a.req0 = 1; bus_a.delay0 = 16'd8;
        expect_sig(c + 15, 0, S_REM, 5);
        expect_sig(c + 15, 0, S_G0, 1);
        to_cycle(c + 15);
        reset = 1'b1;
        bus_a.req0 = 0;
        expect_idle(c + 16, 0);
        to_cycle(c + 16);
        reset = 1'b0;
        c2 = cyc;
        bus_a.req0 = 1; bus_a.delay0 = 16'd2;
        bus_a.req1 = 1; bus_a.delay1 = 16'd1;
        expect_sig(c2 + 1, 0, S_G0, 1);
        expect_sig(c2 + 1, 0, S_G1, 0);
        expect_sig(c2 + 1, 0, S_REM, 2);
        expect_done(c2 + 10, 0, 0);
        expect_sig(c2 + 12, 0, S_G1, 1);
        expect_sig(c2 + 12, 0, S_REM, 1);
        expect_done(c2 + 17, 0, 1);
        to_cycle(c2 + 10);
        bus_a.req0 = 0;
        to_cycle(c2 + 17);
        bus_a.req1 = 0;
        to_cycle(c2 + 19);

        // dut_b (PRESCALE 2): simultaneous requests, each dropped after its done
        c = cyc;
        bus_b.req0 = 1; bus_b.delay0 = 16'd1;
        bus_b.req1 = 1; bus_b.delay1 = 16'd2;
        expect_sig(c + 1, 1, S_G0, 1);
        expect_sig(c + 1, 1, S_G1, 0);
        expect_done(c + 4, 1, 0);
        expect_sig(c + 5, 1, S_BUSY, 0);
        expect_sig(c + 6, 1, S_G1, 1);
        expect_sig(c + 6, 1, S_REM, 2);
        expect_done(c + 11, 1, 1);
        to_cycle(c + 4);
        bus_b.req0 = 0;
        to_cycle(c + 11);
        bus_b.req1 = 0;
        to_cycle(c + 13);

        // dut_b: both held, service alternates 1, 0, 1
        c = cyc;
        bus_b.req1 = 1; bus_b.delay1 = 16'd2;
        expect_sig(c + 1, 1, S_G1, 1);
        expect_done(c + 6, 1, 1);
        expect_sig(c + 8, 1, S_G0, 1);
        expect_sig(c + 8, 1, S_REM, 1);
        expect_done(c + 11, 1, 0);
        expect_sig(c + 13, 1, S_G1, 1);
        expect_sig(c + 13, 1, S_REM, 2);
        expect_done(c + 18, 1, 1);
        to_cycle(c + 1);
        bus_b.req0 = 1; bus_b.delay0 = 16'd1;
        to_cycle(c + 18);
        bus_b.req0 = 0;
        bus_b.req1 = 0;
        to_cycle(c + 20);

        // dut_b: zero delay goes LOAD -> DONE with no counting
        c = cyc;
        bus_b.req1 = 1; bus_b.delay1 = 16'd0;
        expect_sig(c + 1, 1, S_G1, 1);
        expect_sig(c + 1, 1, S_REM, 0);
        expect_sig(c + 1, 1, S_BUSY, 1);
        expect_sig(c + 1, 1, S_D1, 0);
        expect_done(c + 2, 1, 1);
        expect_sig(c + 3, 1, S_BUSY, 0);
        to_cycle(c + 2);
        bus_b.req1 = 0;
        to_cycle(c + 4);

        // dut_c (PRESCALE 1, 8-bit): maximum delay, done in cycle 2^8 + 1
        c = cyc;
        bus_c.req0 = 1; bus_c.delay0 = 8'd255;
        expect_sig(c + 1, 2, S_REM, 255);
        expect_sig(c + 2, 2, S_REM, 255);
        expect_sig(c + 3, 2, S_REM, 254);
        expect_sig(c + 256, 2, S_REM, 1);
        expect_sig(c + 257, 2, S_REM, 0);
        expect_done(c + 257, 2, 0);
        expect_sig(c + 258, 2, S_REM, 0);
        expect_sig(c + 258, 2, S_BUSY, 0);
        to_cycle(c + 257);
        bus_c.req0 = 0;
        to_cycle(c + 260);

        finishing = 1'b1;
        for (int i = 0; i < 5 && !mon_finished; i++) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/delay_timer_arbiter.md
# delay_timer_arbiter

Shares a single programmable step-delay timer between two requesters, e.g. two instruction-sequencing FSMs that each need timed waits for motor stepping and pause instructions. Requesters issue a level request with a delay count. The block grants the timer round-robin, counts the delay in prescaled ticks, and returns a one-cycle done pulse to the granted requester. It sits between the control FSMs and the former per-FSM delay counters, and replaces their start/enable/done handshake.

## Interface
Parameters:
- DELAY_W, 16: width of each requested delay count.
- PRESCALE, 50000: clk cycles per timer tick; legal range 1 to 2^20.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high reset.
- req0, req1  input  1  level request from requester 0 or 1; held high until its done pulse.
- delay0, delay1  input  DELAY_W  tick count for the matching requester; must be stable while its req is high.
- grant0, grant1  output  1  high while the timer is owned by requester 0 or 1; the two are mutually exclusive.
- done0, done1  output  1  one-cycle pulse when the granted delay expires.
- busy  output  1  high whenever the FSM is not in IDLE.
- remaining  output  DELAY_W  ticks left in the current delay; 0 when idle.

## Operation
- The FSM has four states: IDLE, LOAD, COUNT, DONE.
- IDLE:
  - If any req is high, pick the winner and go to LOAD. Latch the winner id, load `remaining` with the winner's delay, and clear the prescaler.
  - Winner selection: if only one req is high, it wins. If both are high, the requester named by priority pointer `ptr` wins.
- LOAD:
  - The granted grant output goes high here and stays high through DONE.
  - If `remaining` == 0, go to DONE. Otherwise go to COUNT.
- COUNT:
  - The prescaler counts 0..PRESCALE-1 and wraps to 0.
  - On each wrap, `remaining` decrements by 1. When a wrap occurs with `remaining` == 1, go to DONE; `remaining` becomes 0.
  - Abort: if the granted requester's req falls during COUNT, go directly to IDLE. No done pulse is issued. Grant drops the next cycle, and `ptr` still flips.
- DONE:
  - The granted done output is high for exactly this cycle.
  - `ptr` is set to the other requester. Go to IDLE.
- req and delay are ignored outside IDLE; only the granted requester's req is watched, for abort.
- A requester that holds req high through the cycle after its done is treated as a new request. The round-robin pointer then favours the other requester if it is waiting.
- Changing delay while req is high is a requester protocol violation. The block uses the value latched in IDLE.

## Timing
- Reset (synchronous, active-high):
  - State IDLE, `ptr` = 0, prescaler = 0.
  - grant0, grant1, done0, done1, busy all 0; `remaining` = 0.
  - Reset asserted mid-COUNT or mid-DONE takes effect at the next edge with these values. Any pending done is lost.
- Latency, with req first sampled high in IDLE at edge 0:
  - LOAD during cycle 1, in which grant goes high.
  - delay = N > 0: COUNT during cycles 2 .. N·PRESCALE+1; done is high in cycle N·PRESCALE+2.
  - delay = 0: done is high in cycle 2.
- Throughput: the earliest next grant is LOAD, two cycles after DONE (DONE, then IDLE, then LOAD). The timer is never granted back-to-back without passing through IDLE.
- PRESCALE = 1: `remaining` decrements every COUNT cycle.
- The prescaler counter is ceil(log2(PRESCALE)) bits wide, with a minimum of 1. `remaining` never underflows.

## Structure
- Shared package `delay_arb_pkg` holds:
  - state encodings IDLE=2'b00, LOAD=2'b01, COUNT=2'b10, DONE=2'b11;
  - the default DELAY_W and PRESCALE constants.
- Sub-module `tick_prescaler` (inputs clk, reset, clear, enable; output tick): a single-cycle pulse every PRESCALE enabled cycles.
- The top module contains the FSM, `ptr`, winner latch, `remaining` register and output decode. Outputs decode from registered state and winner id only; there is no combinational path from req to grant.

## Test plan
- Single request, PRESCALE=4, req0=1 with delay0=3:
  - grant0 rises in cycle 1;
  - done0 is pulsed in cycle 14 only;
  - `remaining` steps 3, 2, 1, 0 on every 4th cycle;
  - grant1 stays 0.
- Simultaneous requests after reset, delay0=1, delay1=2, PRESCALE=2:
  - requester 0 is served first (done0 in cycle 4);
  - requester 1 gets LOAD in cycle 6 and done1 in cycle 11.
  - Repeat with both held: service alternates 1, 0, 1.
- Zero delay, req1=1 with delay1=0: grant1 in cycle 1, done1 in cycle 2, no COUNT cycles.
- Abort: req0 dropped in the 3rd COUNT cycle of a 10-tick delay:
  - no done0 pulse;
  - FSM returns to IDLE and busy falls;
  - a pending req1 gets its LOAD two cycles after the drop.
- Reset mid-operation: assert reset during COUNT with `remaining`=5:
  - next cycle, all outputs are 0 and `ptr`=0;
  - a fresh req0 is granted normally afterwards.
- PRESCALE=1 with delay0 equal to 2^DELAY_W-1: done0 in cycle 2^DELAY_W+1, with no wrap of `remaining`.
